// File: rtl/control_seq.sv
// Two-cycle-per-instruction control sequencer: fetches from a 4x8 program store
// addressed by an external PC and drives increment/jump requests back to it.
module control_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       p1,
  input  logic       p0,
  input  logic       prog_we,
  input  logic [1:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic       inc,
  output logic       jnp,
  output logic       i1,
  output logic       i0,
  output logic       r2,
  output logic [3:0] acc,
  output logic [1:0] state,
  output logic       halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_DEC = 2'b01,
    OP_JNZ = 2'b10,
    OP_HLT = 2'b11
  } opcode_t;

  state_t     cur_state;
  state_t     next_state;
  logic [7:0] store [4];
  logic [7:0] ir;
  logic [3:0] acc_next;
  opcode_t    opcode;

  assign opcode = opcode_t'(ir[7:6]);
  assign state  = cur_state;
  assign halted = (cur_state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // HLT wins over run so a halting program cannot be restarted without reset
  always_comb begin
    next_state = cur_state;
    unique case (cur_state)
      IDLE:    next_state = run ? FETCH : IDLE;
      FETCH:   next_state = EXEC;
      EXEC: begin
        if (opcode == OP_HLT) begin
          next_state = HALT;
        end else if (run) begin
          next_state = FETCH;
        end else begin
          next_state = IDLE;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    inc = 1'b0;
    jnp = 1'b0;
    i1  = 1'b0;
    i0  = 1'b0;
    if (cur_state == EXEC) begin
      unique case (opcode)
        OP_LDI: inc = 1'b1;
        OP_DEC: inc = 1'b1;
        OP_JNZ: begin
          inc = 1'b1;
          jnp = 1'b1;
          i1  = ir[5];
          i0  = ir[4];
        end
        OP_HLT: begin
          inc = 1'b0;
          jnp = 1'b0;
        end
        default: inc = 1'b0;
      endcase
    end
  end

  always_comb begin
    acc_next = acc;
    unique case (opcode)
      OP_LDI:  acc_next = ir[3:0];
      OP_DEC:  acc_next = acc - 4'd1;
      default: acc_next = acc;
    endcase
  end

  // Program writes are only accepted while nothing is executing
  always_ff @(posedge clk) begin
    if (rst) begin
      ir  <= 8'h00;
      acc <= 4'd0;
      r2  <= 1'b1;
      for (int k = 0; k < 4; k++) begin
        store[k] <= 8'h00;
      end
    end else begin
      if (prog_we && (cur_state == IDLE || cur_state == HALT)) begin
        store[prog_addr] <= prog_data;
      end
      if (cur_state == FETCH) begin
        ir <= store[{p1, p0}];
      end
      if (cur_state == EXEC) begin
        acc <= acc_next;
        r2  <= (acc_next == 4'd0);
      end
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: models the external PC, runs a vector
// table of small programs, a scoreboarded countdown loop and reset/FETCH corner cases.
module tb_control_seq;

  typedef struct {
    logic [3:0][7:0] prog;
    int              edges;
    logic [3:0]      exp_acc;
    logic            exp_r2;
    logic [1:0]      exp_state;
    logic [1:0]      exp_pc;
  } vec_t;

  typedef struct packed {
    logic [3:0] acc;
    logic       r2;
    logic [1:0] pc;
  } sb_t;

  logic       clk;
  logic       rst;
  logic       run;
  logic       p1;
  logic       p0;
  logic       prog_we;
  logic [1:0] prog_addr;
  logic [7:0] prog_data;
  logic       inc;
  logic       jnp;
  logic       i1;
  logic       i0;
  logic       r2;
  logic [3:0] acc;
  logic [1:0] state;
  logic       halted;

  logic [1:0] pc;
  logic       pc_load;
  logic [1:0] pc_load_val;

  int   checks;
  int   errors;
  vec_t vecs [5];
  sb_t  sb_q [$];
  logic prev_exec;

  control_seq dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .p1        (p1),
    .p0        (p0),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .inc       (inc),
    .jnp       (jnp),
    .i1        (i1),
    .i0        (i0),
    .r2        (r2),
    .acc       (acc),
    .state     (state),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter stage: jump has priority only when the zero flag is clear
  always @(posedge clk) begin
    if (pc_load) begin
      pc <= pc_load_val;
    end else if (jnp && !r2) begin
      pc <= {i1, i0};
    end else if (inc) begin
      pc <= pc + 2'd1;
    end
  end

  assign p1 = pc[1];
  assign p0 = pc[0];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset(input int n);
    rst         = 1'b1;
    run         = 1'b0;
    prog_we     = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = 2'd0;
    repeat (n) tick();
    rst     = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic setPc(input logic [1:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic loadProgram(input logic [3:0][7:0] p);
    for (int k = 0; k < 4; k++) begin
      prog_we   = 1'b1;
      prog_addr = 2'(k);
      prog_data = p[k];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    doReset(2);
    loadProgram(v.prog);
    run = 1'b1;
    repeat (v.edges) tick();
    run = 1'b0;
  endtask

  // Called once per cycle; the cycle after an EXEC is where the result appears
  task automatic scoreboardStep();
    sb_t e;
    if (prev_exec) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_underflow: got extra EXEC required none");
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_acc", {4'd0, acc}, {4'd0, e.acc});
        checkOutput("sb_r2", {7'd0, r2}, {7'd0, e.r2});
        checkOutput("sb_pc", {6'd0, pc}, {6'd0, e.pc});
      end
    end
    prev_exec = (state == 2'b10);
  endtask

  initial begin
    int halt_cycle;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    run       = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 2'd0;
    prog_data = 8'h00;
    pc_load   = 1'b0;
    pc_load_val = 2'd0;
    prev_exec = 1'b0;

    vecs[0] = '{prog: {8'hC0, 8'h90, 8'h40, 8'h02}, edges: 13, exp_acc: 4'd0, exp_r2: 1'b1, exp_state: 2'b11, exp_pc: 2'd3};
    vecs[1] = '{prog: {8'h00, 8'h00, 8'h00, 8'h40}, edges: 3,  exp_acc: 4'd15, exp_r2: 1'b0, exp_state: 2'b01, exp_pc: 2'd1};
    vecs[2] = '{prog: {8'h00, 8'h00, 8'hC0, 8'h07}, edges: 5,  exp_acc: 4'd7, exp_r2: 1'b0, exp_state: 2'b11, exp_pc: 2'd1};
    vecs[3] = '{prog: {8'hC0, 8'h05, 8'hB0, 8'h00}, edges: 9,  exp_acc: 4'd5, exp_r2: 1'b0, exp_state: 2'b11, exp_pc: 2'd3};
    vecs[4] = '{prog: {8'hC0, 8'h0F, 8'hB0, 8'h01}, edges: 7,  exp_acc: 4'd1, exp_r2: 1'b0, exp_state: 2'b11, exp_pc: 2'd3};

    @(negedge clk);

    // Reset must also wipe a previously loaded store entry
    doReset(1);
    loadProgram({8'h40, 8'h40, 8'h40, 8'h40});
    doReset(2);
    checkOutput("rst_state", {6'd0, state}, 8'h00);
    checkOutput("rst_acc", {4'd0, acc}, 8'h00);
    checkOutput("rst_r2", {7'd0, r2}, 8'h01);
    checkOutput("rst_ctrl", {4'd0, inc, jnp, i1, i0}, 8'h00);
    checkOutput("rst_halted", {7'd0, halted}, 8'h00);
    run = 1'b1;
    tick();
    checkOutput("rst_fetch_state", {6'd0, state}, 8'h01);
    checkOutput("rst_fetch_inc", {7'd0, inc}, 8'h00);
    tick();
    checkOutput("rst_exec_ctrl", {4'd0, inc, jnp, i1, i0}, 8'h08);
    tick();
    checkOutput("rst_store_acc", {4'd0, acc}, 8'h00);
    checkOutput("rst_store_r2", {7'd0, r2}, 8'h01);
    run = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_acc", i), {4'd0, acc}, {4'd0, vecs[i].exp_acc});
      checkOutput($sformatf("vec%0d_r2", i), {7'd0, r2}, {7'd0, vecs[i].exp_r2});
      checkOutput($sformatf("vec%0d_state", i), {6'd0, state}, {6'd0, vecs[i].exp_state});
      checkOutput($sformatf("vec%0d_pc", i), {6'd0, pc}, {6'd0, vecs[i].exp_pc});
    end

    // Countdown loop: LDI 2, DEC, JNZ 1 (taken), DEC, JNZ 1 (not taken), HLT
    doReset(2);
    loadProgram({8'hC0, 8'h90, 8'h40, 8'h02});
    sb_q.push_back('{acc: 4'd2, r2: 1'b0, pc: 2'd1});
    sb_q.push_back('{acc: 4'd1, r2: 1'b0, pc: 2'd2});
    sb_q.push_back('{acc: 4'd1, r2: 1'b0, pc: 2'd1});
    sb_q.push_back('{acc: 4'd0, r2: 1'b1, pc: 2'd2});
    sb_q.push_back('{acc: 4'd0, r2: 1'b1, pc: 2'd3});
    sb_q.push_back('{acc: 4'd0, r2: 1'b1, pc: 2'd3});
    prev_exec  = 1'b0;
    halt_cycle = -1;
    run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      scoreboardStep();
      if (halted === 1'b1) begin
        halt_cycle = c;
        break;
      end
    end
    checkOutput("loop_halt_cycle", 8'(halt_cycle), 8'd13);
    checkOutput("loop_sb_drained", 8'(sb_q.size()), 8'd0);
    checkOutput("loop_halted", {7'd0, halted}, 8'h01);
    checkOutput("loop_acc", {4'd0, acc}, 8'h00);
    checkOutput("loop_r2", {7'd0, r2}, 8'h01);
    checkOutput("loop_halt_ctrl", {4'd0, inc, jnp, i1, i0}, 8'h00);
    run = 1'b0;
    tick();
    tick();
    checkOutput("halt_sticky", {6'd0, state}, 8'h03);
    sb_q.delete();

    // Single DEC from zero: wrap and a one-cycle inc pulse
    doReset(1);
    loadProgram({8'h00, 8'h00, 8'h00, 8'h40});
    run = 1'b1;
    tick();
    checkOutput("dec_inc_fetch", {7'd0, inc}, 8'h00);
    tick();
    checkOutput("dec_inc_exec", {7'd0, inc}, 8'h01);
    run = 1'b0;
    tick();
    checkOutput("dec_inc_after", {7'd0, inc}, 8'h00);
    checkOutput("dec_wrap_acc", {4'd0, acc}, 8'h0F);
    checkOutput("dec_wrap_r2", {7'd0, r2}, 8'h00);

    // Program write attempted during FETCH must be dropped
    doReset(1);
    loadProgram({8'hC0, 8'h03, 8'h02, 8'h01});
    run = 1'b1;
    tick();
    checkOutput("we_fetch_state", {6'd0, state}, 8'h01);
    prog_we   = 1'b1;
    prog_addr = 2'd2;
    prog_data = 8'hFF;
    tick();
    prog_we = 1'b0;
    run     = 1'b0;
    tick();
    setPc(2'd2);
    run = 1'b1;
    repeat (3) tick();
    checkOutput("we_store2_acc", {4'd0, acc}, 8'h03);
    checkOutput("we_store2_state", {6'd0, state}, 8'h01);
    run = 1'b0;

    // run dropped during FETCH of LDI 5
    doReset(1);
    loadProgram({8'h00, 8'h00, 8'h00, 8'h05});
    run = 1'b1;
    tick();
    run = 1'b0;
    checkOutput("drop_fetch_state", {6'd0, state}, 8'h01);
    tick();
    checkOutput("drop_exec_state", {6'd0, state}, 8'h02);
    checkOutput("drop_exec_inc", {7'd0, inc}, 8'h01);
    tick();
    checkOutput("drop_acc", {4'd0, acc}, 8'h05);
    checkOutput("drop_idle", {6'd0, state}, 8'h00);

    // Reset landing on the EXEC of a DEC with acc=3
    doReset(1);
    loadProgram({8'h00, 8'hC0, 8'h40, 8'h03});
    run = 1'b1;
    repeat (4) tick();
    checkOutput("mid_exec_state", {6'd0, state}, 8'h02);
    checkOutput("mid_exec_acc", {4'd0, acc}, 8'h03);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_acc", {4'd0, acc}, 8'h00);
    checkOutput("mid_rst_r2", {7'd0, r2}, 8'h01);
    checkOutput("mid_rst_state", {6'd0, state}, 8'h00);
    checkOutput("mid_rst_inc", {7'd0, inc}, 8'h00);
    rst = 1'b0;
    run = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
